mlaccel_memarb: RTL and testbench
=================================

Name: mlaccel_memarb

Overview:
Arbiter and return-path tracker for the single-port mlaccel_memory macro. It shares the memory between three clients:
- C: compute engine. Highest priority, never stalled.
- Q: host/QPI command path, read/write.
- S: sequencer instruction fetch, read-only.
It issues one access per cycle, tags each read and returns a per-client read-valid strobe exactly MEM_LAT cycles after grant. It also keeps worst-case wait statistics for Q and S. It replaces the ad-hoc client muxing in the top level.

Parameters:
MEM_LAT, 2, cycles from grant to mem_rdata valid (1..4)
WAIT_W, 8, width of the wait counters and max-wait status registers (saturating)

Ports:
clock       in   1   system clock
reset       in   1   synchronous, active-high reset
c_ren       in   1   compute read request (always granted same cycle)
c_wen       in   2   compute byte write enables
c_addr      in   16  compute word address
c_wdata     in   16  compute write data
c_rvalid    out  1   compute read data valid on r_data
q_req       in   1   host request; held until q_gnt
q_wen       in   2   host byte write enables; 0 = read
q_addr      in   16  host address
q_wdata     in   16  host write data
q_gnt       out  1   host granted this cycle (combinational)
q_rvalid    out  1   host read data valid on r_data
s_req       in   1   sequencer read request; held until s_gnt
s_addr      in   16  sequencer address
s_gnt       out  1   sequencer granted this cycle (combinational)
s_rvalid    out  1   sequencer read data valid on r_data
mem_addr    out  16  to memory
mem_wen     out  2   to memory
mem_wdata   out  16  to memory
mem_rdata   in   64  from memory
r_data      out  64  shared read return bus, equal to mem_rdata
clr_stats   in   1   clear the max-wait registers
q_wait_max  out  WAIT_W  longest Q request-to-grant wait seen, in cycles
s_wait_max  out  WAIT_W  longest S request-to-grant wait seen, in cycles

Behaviour:
Granting (combinational within the cycle):
- c_act = c_ren | (c_wen != 0). If c_act, C owns the memory: q_gnt = s_gnt = 0.
- Otherwise Q or S is chosen: fixed priority Q > S (see Optional Feature for round-robin).
- Memory outputs: mem_addr/mem_wen/mem_wdata come from the winner.
- With no winner: mem_addr = c_addr, mem_wen = 0, mem_wdata = c_wdata.
- S never writes.
- While reset = 1: q_gnt = s_gnt = 0 and mem_wen = 0, regardless of requests.

Read tagging:
- A read is any of:
  - C with c_ren = 1 and c_wen = 0;
  - granted Q with q_wen = 0;
  - granted S.
- C with c_ren = 1 and c_wen != 0 is a write only; no rvalid is produced.
- On each read, a 2-bit tag (none/C/Q/S) enters a MEM_LAT-deep shift pipeline.
- The tag at the pipeline output drives exactly one of c_rvalid/q_rvalid/s_rvalid high for one cycle.
- Read latency is exactly MEM_LAT cycles from grant. Back-to-back reads give back-to-back rvalids with no bubbles.
- Writes produce no rvalid. A write completes in its grant cycle.

Wait statistics:
- Per requester, a wait counter counts cycles with req = 1 and gnt = 0. It saturates at 2^WAIT_W−1.
- The counter clears on grant. On the grant cycle, the max register takes max(max, counter).
- clr_stats zeroes both max registers. If clr_stats and an update happen in the same cycle, clr_stats wins.

Reset:
- Clears the tag pipeline: all rvalid = 0 from the next cycle.
- Clears the wait counters, the max registers and the RR pointer.
- Reads in flight when reset rises are dropped: no rvalid is ever issued for them.

Protocol errors (bench asserts; RTL does not fix them):
- q_req or s_req deasserted before grant.
- q_wen or q_addr changing while q_req is pending.

Optional Feature:
MLACCEL_MEMARB_RR_EN
- Defined: Q and S round-robin. A registered last-winner bit selects the non-last client when both request. The bit updates only on a Q/S grant; reset sets it to S, so Q wins first.
- Undefined: fixed Q > S, and S may starve while Q is continuously busy.
- C priority is unchanged in both cases.

Test Plan:
- Q read addr 0x0010, idle bus, MEM_LAT = 2 -> q_gnt in the same cycle, mem_addr = 0x0010, mem_wen = 0; q_rvalid exactly 2 cycles later with r_data = mem model word; c_rvalid and s_rvalid stay 0.
- c_ren held 5 cycles while q_req (write 0xBEEF to 0x0004, wen = 3) is pending -> q_gnt = 0 for 5 cycles, granted on cycle 6 with mem_wen = 3; q_wait_max = 5; no rvalid for the write.
- C, Q and S reads in consecutive cycles -> c_rvalid, q_rvalid, s_rvalid in three consecutive cycles, each 2 cycles after its grant, one-hot.
- q_req and s_req continuously asserted for 6 cycles -> RR_EN defined: grants Q,S,Q,S,Q,S. Undefined: Q six times, s_wait_max = 6.
- Reads issued, then reset pulsed 1 cycle later -> no rvalid afterwards; q_wait_max = s_wait_max = 0; no grant while reset = 1.
- s_req held 300 cycles behind C with WAIT_W = 8 -> s_wait_max = 255 after grant; clr_stats the same cycle -> 0.

Source files
------------

// File: rtl/mlaccel_memarb_if.sv
// Client and memory-side bundle for the mlaccel memory arbiter.
// slave = arbiter side, master = clients + memory macro side.
interface mlaccel_memarb_if;
  logic        c_ren;
  logic [1:0]  c_wen;
  logic [15:0] c_addr;
  logic [15:0] c_wdata;
  logic        c_rvalid;
  logic        q_req;
  logic [1:0]  q_wen;
  logic [15:0] q_addr;
  logic [15:0] q_wdata;
  logic        q_gnt;
  logic        q_rvalid;
  logic        s_req;
  logic [15:0] s_addr;
  logic        s_gnt;
  logic        s_rvalid;
  logic [15:0] mem_addr;
  logic [1:0]  mem_wen;
  logic [15:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic [63:0] r_data;

  modport slave (
    input  c_ren, c_wen, c_addr, c_wdata,
    input  q_req, q_wen, q_addr, q_wdata,
    input  s_req, s_addr, mem_rdata,
    output c_rvalid, q_gnt, q_rvalid,
    output s_gnt, s_rvalid,
    output mem_addr, mem_wen, mem_wdata, r_data
  );

  modport master (
    output c_ren, c_wen, c_addr, c_wdata,
    output q_req, q_wen, q_addr, q_wdata,
    output s_req, s_addr, mem_rdata,
    input  c_rvalid, q_gnt, q_rvalid,
    input  s_gnt, s_rvalid,
    input  mem_addr, mem_wen, mem_wdata, r_data
  );
endinterface

// File: rtl/mlaccel_memarb.sv
// Single-port memory arbiter (C > Q/S) with read-return tagging and wait stats.
// Define MLACCEL_MEMARB_RR_EN for Q/S round-robin instead of fixed Q > S.
module mlaccel_memarb #(
  parameter int MEM_LAT = 2,
  parameter int WAIT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  mlaccel_memarb_if.slave   bus,
  input  logic              clr_stats,
  output logic [WAIT_W-1:0] q_wait_max,
  output logic [WAIT_W-1:0] s_wait_max
);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_C    = 2'd1,
    TAG_Q    = 2'd2,
    TAG_S    = 2'd3
  } tag_e;

  logic c_act;
  logic q_win;
  logic s_win;
  tag_e new_tag;
  tag_e tag_out;

  tag_e tag_q [MEM_LAT];
  tag_e tag_d [MEM_LAT];

  logic [WAIT_W-1:0] q_cnt_q, q_cnt_d;
  logic [WAIT_W-1:0] s_cnt_q, s_cnt_d;
  logic [WAIT_W-1:0] q_max_q, q_max_d;
  logic [WAIT_W-1:0] s_max_q, s_max_d;

`ifdef MLACCEL_MEMARB_RR_EN
  logic last_s_q, last_s_d;
`endif

  assign c_act = bus.c_ren | (|bus.c_wen);

  always_comb begin
    q_win = 1'b0;
    s_win = 1'b0;
    if (!reset && !c_act) begin
`ifdef MLACCEL_MEMARB_RR_EN
      if (bus.q_req && bus.s_req) begin
        q_win = last_s_q;
        s_win = ~last_s_q;
      end else begin
        q_win = bus.q_req;
        s_win = bus.s_req;
      end
`else
      q_win = bus.q_req;
      s_win = bus.s_req & ~bus.q_req;
`endif
    end
  end

  assign bus.q_gnt = q_win;
  assign bus.s_gnt = s_win;

  always_comb begin
    bus.mem_addr  = bus.c_addr;
    bus.mem_wen   = 2'b00;
    bus.mem_wdata = bus.c_wdata;
    if (q_win) begin
      bus.mem_addr  = bus.q_addr;
      bus.mem_wen   = bus.q_wen;
      bus.mem_wdata = bus.q_wdata;
    end else if (s_win) begin
      bus.mem_addr  = bus.s_addr;
    end else if (c_act && !reset) begin
      bus.mem_wen   = bus.c_wen;
    end
  end

  // a C access with any byte enable set is a pure write
  always_comb begin
    new_tag = TAG_NONE;
    if (reset)
      new_tag = TAG_NONE;
    else if (bus.c_ren && (bus.c_wen == 2'b00))
      new_tag = TAG_C;
    else if (q_win && (bus.q_wen == 2'b00))
      new_tag = TAG_Q;
    else if (s_win)
      new_tag = TAG_S;
  end

  always_comb begin
    tag_d[0] = new_tag;
    for (int i = 1; i < MEM_LAT; i++)
      tag_d[i] = tag_q[i-1];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < MEM_LAT; i++)
        tag_q[i] <= TAG_NONE;
    end else begin
      for (int i = 0; i < MEM_LAT; i++)
        tag_q[i] <= tag_d[i];
    end
  end

  // gating with reset drops in-flight reads in the reset cycle too
  assign tag_out      = tag_q[MEM_LAT-1];
  assign bus.c_rvalid = !reset && (tag_out == TAG_C);
  assign bus.q_rvalid = !reset && (tag_out == TAG_Q);
  assign bus.s_rvalid = !reset && (tag_out == TAG_S);
  assign bus.r_data   = bus.mem_rdata;

  always_comb begin
    q_cnt_d = q_cnt_q;
    q_max_d = q_max_q;
    if (q_win) begin
      q_cnt_d = '0;
      if (q_cnt_q > q_max_q)
        q_max_d = q_cnt_q;
    end else if (bus.q_req) begin
      if (q_cnt_q != '1)
        q_cnt_d = q_cnt_q + 1'b1;
    end else begin
      q_cnt_d = '0;
    end
    if (clr_stats)
      q_max_d = '0;
  end

  always_comb begin
    s_cnt_d = s_cnt_q;
    s_max_d = s_max_q;
    if (s_win) begin
      s_cnt_d = '0;
      if (s_cnt_q > s_max_q)
        s_max_d = s_cnt_q;
    end else if (bus.s_req) begin
      if (s_cnt_q != '1)
        s_cnt_d = s_cnt_q + 1'b1;
    end else begin
      s_cnt_d = '0;
    end
    if (clr_stats)
      s_max_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q_cnt_q <= '0;
      s_cnt_q <= '0;
      q_max_q <= '0;
      s_max_q <= '0;
    end else begin
      q_cnt_q <= q_cnt_d;
      s_cnt_q <= s_cnt_d;
      q_max_q <= q_max_d;
      s_max_q <= s_max_d;
    end
  end

`ifdef MLACCEL_MEMARB_RR_EN
  always_comb begin
    last_s_d = last_s_q;
    if (q_win)
      last_s_d = 1'b0;
    else if (s_win)
      last_s_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset)
      last_s_q <= 1'b1;
    else
      last_s_q <= last_s_d;
  end
`endif

  assign q_wait_max = q_max_q;
  assign s_wait_max = s_max_q;

endmodule

// File: tb/tb_mlaccel_memarb.sv
// Directed + random bench for mlaccel_memarb against a cycle-level reference model.
// Honours MLACCEL_MEMARB_RR_EN the same way as the design.
module tb_mlaccel_memarb;
  localparam int MEM_LAT = 2;
  localparam int WAIT_W  = 8;
  localparam int SAT     = (1 << WAIT_W) - 1;

  logic              clock = 1'b0;
  logic              reset;
  logic              clr_stats;
  logic [WAIT_W-1:0] q_wait_max;
  logic [WAIT_W-1:0] s_wait_max;

  mlaccel_memarb_if bus();

  mlaccel_memarb #(.MEM_LAT(MEM_LAT), .WAIT_W(WAIT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .clr_stats  (clr_stats),
    .q_wait_max (q_wait_max),
    .s_wait_max (s_wait_max)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] word(input logic [15:0] a);
    return {a ^ 16'h5a5a, ~a, a, a + 16'h1234};
  endfunction

  // memory macro: word for the address presented MEM_LAT cycles ago
  logic [15:0] hist [MEM_LAT];
  always @(posedge clock) begin
    hist[0] <= bus.mem_addr;
    for (int i = 1; i < MEM_LAT; i++) hist[i] <= hist[i-1];
  end
  assign bus.mem_rdata = word(hist[MEM_LAT-1]);

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int m_qw, m_sw, m_qmax, m_smax;
  bit m_last_s = 1'b1;
  int sch_cl [16];
  logic [15:0] sch_ad [16];
  bit q_pend, s_pend;
  logic [1:0] pw;
  logic [15:0] pa, psa;
  bit last_gq, last_gs;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sched(input int cl, input logic [15:0] a);
    sch_cl[(cyc + MEM_LAT) % 16] = cl;
    sch_ad[(cyc + MEM_LAT) % 16] = a;
  endtask

  task automatic step();
    bit cact, gq, gs;
    logic [15:0] ea;
    logic [1:0] ew;
    int rc;
    logic [15:0] ra;
    @(negedge clock);
    if (q_pend)
      chk("q_hold", {bus.q_req, bus.q_wen, bus.q_addr}, {1'b1, pw, pa});
    if (s_pend)
      chk("s_hold", {bus.s_req, bus.s_addr}, {1'b1, psa});
    cact = bus.c_ren || (bus.c_wen != 2'b00);
    gq = 1'b0;
    gs = 1'b0;
    if (!reset && !cact) begin
`ifdef MLACCEL_MEMARB_RR_EN
      if (bus.q_req && bus.s_req) begin
        gq = m_last_s;
        gs = !m_last_s;
      end else begin
        gq = bus.q_req;
        gs = bus.s_req;
      end
`else
      gq = bus.q_req;
      gs = bus.s_req && !bus.q_req;
`endif
    end
    ea = gq ? bus.q_addr : (gs ? bus.s_addr : bus.c_addr);
    ew = reset ? 2'b00 : (gq ? bus.q_wen :
         (gs ? 2'b00 : (cact ? bus.c_wen : 2'b00)));
    chk("q_gnt", bus.q_gnt, gq);
    chk("s_gnt", bus.s_gnt, gs);
    chk("mem_addr", bus.mem_addr, ea);
    chk("mem_wen", bus.mem_wen, ew);
    if (gq) chk("mem_wdata_q", bus.mem_wdata, bus.q_wdata);
    else if (!gs) chk("mem_wdata_c", bus.mem_wdata, bus.c_wdata);
    rc = reset ? 0 : sch_cl[cyc % 16];
    ra = sch_ad[cyc % 16];
    chk("rvalid", {bus.c_rvalid, bus.q_rvalid, bus.s_rvalid},
        {rc == 1, rc == 2, rc == 3});
    chk("r_data_bus", bus.r_data, bus.mem_rdata);
    if (rc != 0) chk("r_data", bus.r_data, word(ra));
    chk("q_wait_max", q_wait_max, m_qmax);
    chk("s_wait_max", s_wait_max, m_smax);
    sch_cl[cyc % 16] = 0;
    if (reset) begin
      for (int i = 0; i < 16; i++) sch_cl[i] = 0;
      m_qw = 0; m_sw = 0; m_qmax = 0; m_smax = 0;
      m_last_s = 1'b1;
    end else begin
      if (bus.c_ren && bus.c_wen == 2'b00) sched(1, bus.c_addr);
      else if (gq && bus.q_wen == 2'b00) sched(2, bus.q_addr);
      else if (gs) sched(3, bus.s_addr);
      if (gq) begin
        if (m_qw > m_qmax) m_qmax = m_qw;
        m_qw = 0;
      end else if (bus.q_req) m_qw = (m_qw < SAT) ? m_qw + 1 : SAT;
      else m_qw = 0;
      if (gs) begin
        if (m_sw > m_smax) m_smax = m_sw;
        m_sw = 0;
      end else if (bus.s_req) m_sw = (m_sw < SAT) ? m_sw + 1 : SAT;
      else m_sw = 0;
      if (clr_stats) begin m_qmax = 0; m_smax = 0; end
      if (gq) m_last_s = 1'b0;
      if (gs) m_last_s = 1'b1;
    end
    q_pend = !reset && bus.q_req && !gq;
    pw = bus.q_wen; pa = bus.q_addr;
    s_pend = !reset && bus.s_req && !gs;
    psa = bus.s_addr;
    last_gq = gq;
    last_gs = gs;
    cyc++;
    @(posedge clock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin sch_cl[i] = 0; sch_ad[i] = '0; end
    m_qw = 0; m_sw = 0; m_qmax = 0; m_smax = 0;
    reset = 1'b1; clr_stats = 1'b0;
    bus.c_ren = 0; bus.c_wen = 0; bus.c_addr = 0; bus.c_wdata = 0;
    bus.q_req = 0; bus.q_wen = 0; bus.q_addr = 0; bus.q_wdata = 0;
    bus.s_req = 0; bus.s_addr = 0;
    @(posedge clock); #1;
    step(); step();
    reset = 1'b0;
    step();
    chk("reset_qmax", q_wait_max, 0);
    chk("reset_smax", s_wait_max, 0);

    // Q read on idle bus
    bus.q_req = 1; bus.q_wen = 0; bus.q_addr = 16'h0010;
    step();
    bus.q_req = 0;
    repeat (3) step();

    // Q write held off by 5 cycles of C reads
    bus.c_ren = 1; bus.c_addr = 16'h0100;
    bus.q_req = 1; bus.q_wen = 2'b11; bus.q_addr = 16'h0004;
    bus.q_wdata = 16'hBEEF;
    repeat (5) step();
    bus.c_ren = 0;
    step();
    bus.q_req = 0; bus.q_wen = 0;
    repeat (2) step();
    chk("tp_q_wait_max5", q_wait_max, 5);

    // C, Q, S reads back to back
    bus.c_ren = 1; bus.c_addr = 16'h0020;
    step();
    bus.c_ren = 0; bus.q_req = 1; bus.q_addr = 16'h0030;
    step();
    bus.q_req = 0; bus.s_req = 1; bus.s_addr = 16'h0040;
    step();
    bus.s_req = 0;
    repeat (4) step();

    // Q and S both requesting for 6 cycles
    bus.q_req = 1; bus.q_addr = 16'h0200;
    bus.s_req = 1; bus.s_addr = 16'h0300;
    repeat (6) begin
      step();
      if (last_gq) bus.q_addr = bus.q_addr + 1;
      if (last_gs) bus.s_addr = bus.s_addr + 1;
    end
    bus.q_req = 0;
    step();
    bus.s_req = 0;
    repeat (3) step();
`ifdef MLACCEL_MEMARB_RR_EN
    chk("tp_s_wait_rr", s_wait_max, 1);
`else
    chk("tp_s_wait_fixed", s_wait_max, 6);
`endif

    // reads in flight, then reset
    bus.c_ren = 1; bus.c_addr = 16'h0050;
    bus.q_req = 1; bus.q_addr = 16'h0060;
    step();
    bus.c_wen = 2'b11; reset = 1;
    step();
    reset = 0; bus.c_ren = 0; bus.c_wen = 0; bus.q_req = 0;
    repeat (4) step();
    chk("tp_rst_qmax", q_wait_max, 0);
    chk("tp_rst_smax", s_wait_max, 0);

    // S starved by C for 300 cycles: counter saturates
    bus.c_ren = 1; bus.s_req = 1; bus.s_addr = 16'h0070;
    repeat (300) step();
    bus.c_ren = 0;
    step();
    bus.s_req = 0;
    step();
    chk("tp_s_sat", s_wait_max, SAT);
    bus.c_ren = 1; bus.s_req = 1;
    repeat (3) step();
    bus.c_ren = 0; clr_stats = 1;
    step();
    clr_stats = 0; bus.s_req = 0;
    step();
    chk("tp_clr_wins", s_wait_max, 0);

    // random traffic
    repeat (500) begin
      bus.c_ren = ($urandom % 4) == 0;
      bus.c_wen = (($urandom % 6) == 0) ? 2'($urandom) : 2'b00;
      bus.c_addr = 16'($urandom);
      bus.c_wdata = 16'($urandom);
      if (!q_pend) begin
        bus.q_req = $urandom % 2;
        bus.q_wen = (($urandom % 3) == 0) ? 2'($urandom) : 2'b00;
        bus.q_addr = 16'($urandom);
        bus.q_wdata = 16'($urandom);
      end
      if (!s_pend) begin
        bus.s_req = $urandom % 2;
        bus.s_addr = 16'($urandom);
      end
      clr_stats = ($urandom % 50) == 0;
      reset = ($urandom % 97) == 0;
      step();
    end
    reset = 0; clr_stats = 0;
    bus.c_ren = 0; bus.c_wen = 0; bus.q_req = 0; bus.s_req = 0;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
